lc3_control_unit: RTL and testbench

//  Moore FSM sequencing the LC-3 Datapath: fetch, decode and execute of the supported opcode subset.

---
 rtl/lc3_ctrl_pkg.sv | 85 ++++++++
 rtl/lc3_control_unit_if.sv | 32 +++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/lc3_control_unit.sv | 172 +++++++++++++++++
 tb/tb_lc3_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and constants for the LC-3 control unit.
//  state_t : FSM state encoding, also exported on State_Dbg
//  Op*     : opcode values of IR[15:12]
//  mux/ALU select encodings used by the datapath
//  ctrl_t  : bundle of every control output, decoded from the current state
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    StHalted = 5'd0,
    StFetch1 = 5'd1,
    StFetch2 = 5'd2,
    StFetch3 = 5'd3,
    StDecode = 5'd4,
    StAdd    = 5'd5,
    StAnd    = 5'd6,
    StNot    = 5'd7,
    StBrTake = 5'd8,
    StJmp    = 5'd9,
    StJsr1   = 5'd10,
    StJsr2   = 5'd11,
    StJsrr   = 5'd12,
    StLdr1   = 5'd13,
    StLdr2   = 5'd14,
    StLdr3   = 5'd15,
    StStr1   = 5'd16,
    StStr2   = 5'd17,
    StStr3   = 5'd18,
    StPause1 = 5'd19,
    StPause2 = 5'd20
  } state_t;

  localparam logic [3:0] OpBr    = 4'b0000;
  localparam logic [3:0] OpAdd   = 4'b0001;
  localparam logic [3:0] OpJsr   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpLdr   = 4'b0110;
  localparam logic [3:0] OpStr   = 4'b0111;
  localparam logic [3:0] OpNot   = 4'b1001;
  localparam logic [3:0] OpJmp   = 4'b1100;
  localparam logic [3:0] OpPause = 4'b1101;

  localparam logic [1:0] PcmuxInc  = 2'b00;
  localparam logic [1:0] PcmuxBus  = 2'b01;
  localparam logic [1:0] PcmuxAddr = 2'b10;

  localparam logic [1:0] DrmuxIr11 = 2'b00;
  localparam logic [1:0] DrmuxR7   = 2'b01;

  localparam logic [1:0] Sr1muxIr11 = 2'b00;
  localparam logic [1:0] Sr1muxIr8  = 2'b01;

  localparam logic [1:0] Addr2Zero  = 2'b00;
  localparam logic [1:0] Addr2Off6  = 2'b01;
  localparam logic [1:0] Addr2Off9  = 2'b10;
  localparam logic [1:0] Addr2Off11 = 2'b11;

  localparam logic [1:0] AlukAdd  = 2'b00;
  localparam logic [1:0] AlukAnd  = 2'b01;
  localparam logic [1:0] AlukNot  = 2'b10;
  localparam logic [1:0] AlukPass = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       addr1mux;
    logic       marmux;
    logic [1:0] addr2mux;
    logic [1:0] pcmux;
    logic [1:0] drmux;
    logic [1:0] sr1mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       mem_wr;
  } ctrl_t;

endpackage

// File: rtl/lc3_control_unit_if.sv
// Control-unit <-> datapath/RAM signal bundle.
//  master : control unit (drives loads, gates, selects, RAM strobes, State_Dbg)
//  slave  : datapath/RAM side (drives Run, Continue, IR fields, BEN)
interface lc3_control_unit_if;
  logic       Run;
  logic       Continue;
  logic [3:0] IR_15_12;
  logic       IR_11;
  logic       BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       ADDR1MUX, MARMUX;
  logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
  logic       MIO_EN, MEM_WR;
  logic [4:0] State_Dbg;

  modport master (
    input  Run, Continue, IR_15_12, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output ADDR1MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
    output MIO_EN, MEM_WR, State_Dbg
  );

  modport slave (
    output Run, Continue, IR_15_12, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  ADDR1MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
    input  MIO_EN, MEM_WR, State_Dbg
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Stretches a memory state to MEM_WAIT cycles.
//  clk_i    : clock
//  rst_ni   : synchronous active-low reset
//  active_i : FSM is in a memory state
//  done_o   : last cycle of the memory state (counter == MEM_WAIT-1)
// The counter sits at 0 outside memory states, so every entry starts from 0.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  output logic done_o
);
  localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done_o = active_i && (cnt_q == CntW'(MEM_WAIT - 1));
  // Clear on the exit cycle as well, so back-to-back memory states would also start at 0.
  assign cnt_d  = (active_i && !done_o) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/lc3_control_unit.sv
// Moore FSM sequencing the LC-3 datapath through fetch, decode and execute.
//  Clk   : clock, rising edge
//  Reset : synchronous active-low reset, returns to HALTED from any state
//  bus   : lc3_control_unit_if.master -- IR/BEN/Run/Continue in; loads, gates,
//          mux selects, RAM strobes and State_Dbg out
// Outputs depend only on the state register and the wait counter.
module lc3_control_unit #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  lc3_control_unit_if.master   bus
);
  import lc3_ctrl_pkg::*;

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_active, mem_done;

  assign mem_active = (state_q == StFetch2) || (state_q == StLdr2) || (state_q == StStr3);

  mem_wait_timer #(
    .MEM_WAIT(MEM_WAIT)
  ) u_mem_wait_timer (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .active_i(mem_active),
    .done_o  (mem_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StHalted;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalted: if (bus.Run) state_d = StFetch1;
      StFetch1: state_d = StFetch2;
      StFetch2: if (mem_done) state_d = StFetch3;
      StFetch3: state_d = StDecode;
      StDecode: begin
        unique case (bus.IR_15_12)
          OpAdd:   state_d = StAdd;
          OpAnd:   state_d = StAnd;
          OpNot:   state_d = StNot;
          OpBr:    state_d = bus.BEN ? StBrTake : StFetch1;
          OpJmp:   state_d = StJmp;
          OpJsr:   state_d = StJsr1;
          OpLdr:   state_d = StLdr1;
          OpStr:   state_d = StStr1;
          OpPause: state_d = StPause1;
          default: state_d = StFetch1;
        endcase
      end
      StAdd, StAnd, StNot, StBrTake, StJmp, StJsr2, StJsrr, StLdr3: state_d = StFetch1;
      StJsr1:   state_d = bus.IR_11 ? StJsr2 : StJsrr;
      StLdr1:   state_d = StLdr2;
      StLdr2:   if (mem_done) state_d = StLdr3;
      StStr1:   state_d = StStr2;
      StStr2:   state_d = StStr3;
      StStr3:   if (mem_done) state_d = StFetch1;
      StPause1: if (bus.Continue) state_d = StPause2;
      StPause2: if (!bus.Continue) state_d = StFetch1;
      default:  state_d = StHalted;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch1: begin
        ctrl.ld_mar  = 1'b1;
        ctrl.gate_pc = 1'b1;
        ctrl.ld_pc   = 1'b1;
        ctrl.pcmux   = PcmuxInc;
      end
      StFetch2, StLdr2: begin
        ctrl.mio_en = 1'b1;
        ctrl.ld_mdr = mem_done;
      end
      StFetch3: begin
        ctrl.ld_ir    = 1'b1;
        ctrl.gate_mdr = 1'b1;
      end
      StDecode: ctrl.ld_ben = 1'b1;
      StAdd, StAnd, StNot: begin
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        ctrl.gate_alu = 1'b1;
        ctrl.sr1mux   = Sr1muxIr8;
        ctrl.drmux    = DrmuxIr11;
        ctrl.aluk     = (state_q == StAdd) ? AlukAdd :
                        (state_q == StAnd) ? AlukAnd : AlukNot;
      end
      StBrTake: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.addr1mux = 1'b0;
        ctrl.addr2mux = Addr2Off9;
        ctrl.pcmux    = PcmuxAddr;
      end
      // JMP and JSRR both take PC from BaseR = IR[8:6].
      StJmp, StJsrr: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.addr1mux = 1'b1;
        ctrl.addr2mux = Addr2Zero;
        ctrl.pcmux    = PcmuxAddr;
        ctrl.sr1mux   = Sr1muxIr8;
      end
      StJsr1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_reg  = 1'b1;
        ctrl.drmux   = DrmuxR7;
      end
      StJsr2: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.addr1mux = 1'b0;
        ctrl.addr2mux = Addr2Off11;
        ctrl.pcmux    = PcmuxAddr;
      end
      StLdr1, StStr1: begin
        ctrl.ld_mar      = 1'b1;
        ctrl.gate_marmux = 1'b1;
        ctrl.marmux      = 1'b1;
        ctrl.addr1mux    = 1'b1;
        ctrl.addr2mux    = Addr2Off6;
        ctrl.sr1mux      = Sr1muxIr8;
      end
      StLdr3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        ctrl.drmux    = DrmuxIr11;
      end
      // Store data passes through the ALU into MDR; MIO_EN low selects the bus.
      StStr2: begin
        ctrl.sr1mux   = Sr1muxIr11;
        ctrl.aluk     = AlukPass;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
      end
      StStr3:  ctrl.mem_wr = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign bus.LD_MAR     = ctrl.ld_mar;
  assign bus.LD_MDR     = ctrl.ld_mdr;
  assign bus.LD_IR      = ctrl.ld_ir;
  assign bus.LD_BEN     = ctrl.ld_ben;
  assign bus.LD_REG     = ctrl.ld_reg;
  assign bus.LD_CC      = ctrl.ld_cc;
  assign bus.LD_PC      = ctrl.ld_pc;
  assign bus.GatePC     = ctrl.gate_pc;
  assign bus.GateMDR    = ctrl.gate_mdr;
  assign bus.GateALU    = ctrl.gate_alu;
  assign bus.GateMARMUX = ctrl.gate_marmux;
  assign bus.ADDR1MUX   = ctrl.addr1mux;
  assign bus.MARMUX     = ctrl.marmux;
  assign bus.ADDR2MUX   = ctrl.addr2mux;
  assign bus.PCMUX      = ctrl.pcmux;
  assign bus.DRMUX      = ctrl.drmux;
  assign bus.SR1MUX     = ctrl.sr1mux;
  assign bus.ALUK       = ctrl.aluk;
  assign bus.MIO_EN     = ctrl.mio_en;
  assign bus.MEM_WR     = ctrl.mem_wr;
  assign bus.State_Dbg  = state_q;
endmodule

// File: tb/tb_lc3_control_unit.sv
// Directed bench for lc3_control_unit (MEM_WAIT=2). Drives opcode/BEN/IR_11
// directly and checks the state walk plus every decoded output each cycle.
module tb_lc3_control_unit;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  lc3_control_unit_if bus ();

  lc3_control_unit #(
    .MEM_WAIT(2)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output vector, MSB first:
  // LD_MAR LD_MDR LD_IR LD_BEN LD_REG LD_CC LD_PC GatePC GateMDR GateALU GateMARMUX
  // ADDR1MUX MARMUX ADDR2MUX[1:0] PCMUX[1:0] DRMUX[1:0] SR1MUX[1:0] ALUK[1:0] MIO_EN MEM_WR
  logic [24:0] obs;
  assign obs = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_REG, bus.LD_CC,
                bus.LD_PC, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                bus.ADDR1MUX, bus.MARMUX, bus.ADDR2MUX, bus.PCMUX, bus.DRMUX,
                bus.SR1MUX, bus.ALUK, bus.MIO_EN, bus.MEM_WR};

  localparam logic [24:0] LdMar  = 25'd1 << 24;
  localparam logic [24:0] LdMdr  = 25'd1 << 23;
  localparam logic [24:0] LdIr   = 25'd1 << 22;
  localparam logic [24:0] LdBen  = 25'd1 << 21;
  localparam logic [24:0] LdReg  = 25'd1 << 20;
  localparam logic [24:0] LdCc   = 25'd1 << 19;
  localparam logic [24:0] LdPc   = 25'd1 << 18;
  localparam logic [24:0] GPc    = 25'd1 << 17;
  localparam logic [24:0] GMdr   = 25'd1 << 16;
  localparam logic [24:0] GAlu   = 25'd1 << 15;
  localparam logic [24:0] GMarmx = 25'd1 << 14;
  localparam logic [24:0] Addr1  = 25'd1 << 13;
  localparam logic [24:0] Marmx  = 25'd1 << 12;
  localparam logic [24:0] Mio    = 25'd1 << 1;
  localparam logic [24:0] MemWr  = 25'd1;

  localparam logic [24:0] EF1   = LdMar | GPc | LdPc;                     // PCMUX=00
  localparam logic [24:0] EF2W  = Mio;
  localparam logic [24:0] EF2L  = Mio | LdMdr;
  localparam logic [24:0] EF3   = LdIr | GMdr;
  localparam logic [24:0] EDec  = LdBen;
  localparam logic [24:0] EAlu  = LdReg | LdCc | GAlu | (25'd1 << 4);     // SR1MUX=01 ALUK=00
  localparam logic [24:0] EBr   = LdPc | (25'd2 << 10) | (25'd2 << 8);    // ADDR2=10 PCMUX=10
  localparam logic [24:0] EJmp  = LdPc | Addr1 | (25'd2 << 8) | (25'd1 << 4);
  localparam logic [24:0] EJsr1 = GPc | LdReg | (25'd1 << 6);             // DRMUX=01
  localparam logic [24:0] EJsr2 = LdPc | (25'd3 << 10) | (25'd2 << 8);    // ADDR2=11
  localparam logic [24:0] EAdr6 = LdMar | GMarmx | Marmx | Addr1 | (25'd1 << 10) | (25'd1 << 4);
  localparam logic [24:0] ELdr3 = GMdr | LdReg | LdCc;
  localparam logic [24:0] EStr2 = GAlu | LdMdr | (25'd3 << 2);            // SR1MUX=00 ALUK=11
  localparam logic [24:0] EStr3 = MemWr;

  localparam logic [4:0] SHalt = 5'd0,  SF1 = 5'd1,   SF2 = 5'd2,   SF3 = 5'd3,  SDec = 5'd4;
  localparam logic [4:0] SAdd = 5'd5,   SAnd = 5'd6,  SNot = 5'd7,  SBrT = 5'd8, SJmp = 5'd9;
  localparam logic [4:0] SJsr1 = 5'd10, SJsr2 = 5'd11, SJsrr = 5'd12;
  localparam logic [4:0] SLdr1 = 5'd13, SLdr2 = 5'd14, SLdr3 = 5'd15;
  localparam logic [4:0] SStr1 = 5'd16, SStr2 = 5'd17, SStr3 = 5'd18;
  localparam logic [4:0] SP1 = 5'd19,   SP2 = 5'd20;

  // Expected {state, outputs} for the first four negedges after FETCH1.
  function automatic logic [29:0] pre(input int c);
    case (c)
      0:       return {SF2, EF2W};
      1:       return {SF2, EF2L};
      2:       return {SF3, EF3};
      default: return {SDec, EDec};
    endcase
  endfunction

  task automatic test_reset();
    bus.Run = 1'b1;
    Reset   = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (bus.State_Dbg !== SHalt) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", bus.State_Dbg, SHalt);
    end
    n_cmp++;
    if (obs !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want %h", obs, 25'd0);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({bus.State_Dbg, obs} !== {SF1, EF1}) begin
      n_err++;
      $display("FAIL run_to_fetch1: got state=%0d outs=%h want state=%0d outs=%h",
               bus.State_Dbg, obs, SF1, EF1);
    end
    bus.Run = 1'b0;  // must not matter mid-instruction
  endtask

  task automatic test_alu();
    logic [29:0] exp;
    logic [3:0]  op [4];
    logic [29:0] ex [4];
    op[0] = 4'b0001; ex[0] = {SAdd, EAlu};
    op[1] = 4'b0101; ex[1] = {SAnd, EAlu | (25'd1 << 2)};
    op[2] = 4'b1001; ex[2] = {SNot, EAlu | (25'd2 << 2)};
    op[3] = 4'b1010; ex[3] = {SF1, EF1};  // unsupported opcode: NOP
    for (int k = 0; k < 4; k++) begin
      bus.IR_15_12 = op[k];
      for (int c = 0; c < ((k == 3) ? 5 : 6); c++) begin
        exp = (c < 4) ? pre(c) : ((c == 4) ? ex[k] : {SF1, EF1});
        @(negedge Clk);
        n_cmp++;
        if ({bus.State_Dbg, obs} !== exp) begin
          n_err++;
          $display("FAIL alu op=%b cyc %0d: got state=%0d outs=%h want state=%0d outs=%h",
                   op[k], c, bus.State_Dbg, obs, exp[29:25], exp[24:0]);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [29:0] exp;
    logic [3:0]  op [3];
    logic        ben [3];
    logic [29:0] mid [3];
    int          len [3];
    op[0] = 4'b0000; ben[0] = 1'b1; mid[0] = {SBrT, EBr};  len[0] = 6;
    op[1] = 4'b0000; ben[1] = 1'b0; mid[1] = {SF1, EF1};   len[1] = 5;
    op[2] = 4'b1100; ben[2] = 1'b1; mid[2] = {SJmp, EJmp}; len[2] = 6;
    for (int k = 0; k < 3; k++) begin
      bus.IR_15_12 = op[k];
      bus.BEN      = ben[k];
      for (int c = 0; c < len[k]; c++) begin
        exp = (c < 4) ? pre(c) : ((c == 4) ? mid[k] : {SF1, EF1});
        @(negedge Clk);
        n_cmp++;
        if ({bus.State_Dbg, obs} !== exp) begin
          n_err++;
          $display("FAIL branch[%0d] cyc %0d: got state=%0d outs=%h want state=%0d outs=%h",
                   k, c, bus.State_Dbg, obs, exp[29:25], exp[24:0]);
        end
      end
    end
    bus.BEN = 1'b0;
  endtask

  task automatic test_jsr();
    logic [29:0] exp;
    logic [29:0] tgt [2];
    tgt[0] = {SJsr2, EJsr2};  // IR_11=1: PC <- PC + off11
    tgt[1] = {SJsrr, EJmp};   // IR_11=0: PC <- BaseR
    bus.IR_15_12 = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      bus.IR_11 = (k == 0);
      for (int c = 0; c < 7; c++) begin
        if (c < 4)       exp = pre(c);
        else if (c == 4) exp = {SJsr1, EJsr1};
        else if (c == 5) exp = tgt[k];
        else             exp = {SF1, EF1};
        @(negedge Clk);
        n_cmp++;
        if ({bus.State_Dbg, obs} !== exp) begin
          n_err++;
          $display("FAIL jsr ir11=%0d cyc %0d: got state=%0d outs=%h want state=%0d outs=%h",
                   bus.IR_11, c, bus.State_Dbg, obs, exp[29:25], exp[24:0]);
        end
      end
    end
    bus.IR_11 = 1'b0;
  endtask

  task automatic test_mem();
    logic [29:0] exp;
    logic [3:0]  op [2];
    logic [29:0] tl [2][5];
    int          wr_cycles;
    op[0] = 4'b0111;
    tl[0][0] = {SStr1, EAdr6}; tl[0][1] = {SStr2, EStr2}; tl[0][2] = {SStr3, EStr3};
    tl[0][3] = {SStr3, EStr3}; tl[0][4] = {SF1, EF1};
    op[1] = 4'b0110;
    tl[1][0] = {SLdr1, EAdr6}; tl[1][1] = {SLdr2, EF2W}; tl[1][2] = {SLdr2, EF2L};
    tl[1][3] = {SLdr3, ELdr3}; tl[1][4] = {SF1, EF1};
    for (int k = 0; k < 2; k++) begin
      bus.IR_15_12 = op[k];
      wr_cycles    = 0;
      for (int c = 0; c < 9; c++) begin
        exp = (c < 4) ? pre(c) : tl[k][c-4];
        @(negedge Clk);
        if (bus.MEM_WR === 1'b1) wr_cycles++;
        n_cmp++;
        if ({bus.State_Dbg, obs} !== exp) begin
          n_err++;
          $display("FAIL mem op=%b cyc %0d: got state=%0d outs=%h want state=%0d outs=%h",
                   op[k], c, bus.State_Dbg, obs, exp[29:25], exp[24:0]);
        end
      end
      n_cmp++;
      if (wr_cycles != ((k == 0) ? 2 : 0)) begin
        n_err++;
        $display("FAIL mem_wr_width op=%b: got %0d cycles want %0d",
                 op[k], wr_cycles, (k == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_pause();
    logic [29:0] exp;
    bus.IR_15_12 = 4'b1101;
    bus.Continue = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4)      exp = pre(c);
      else if (c < 7) exp = {SP1, 25'd0};
      else if (c < 9) exp = {SP2, 25'd0};
      else            exp = {SF1, EF1};
      @(negedge Clk);
      n_cmp++;
      if ({bus.State_Dbg, obs} !== exp) begin
        n_err++;
        $display("FAIL pause cyc %0d: got state=%0d outs=%h want state=%0d outs=%h",
                 c, bus.State_Dbg, obs, exp[29:25], exp[24:0]);
      end
      bus.Continue = (c == 6) || (c == 7);
    end
    bus.Continue = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.IR_15_12 = 4'b0001;
    @(negedge Clk);
    n_cmp++;
    if ({bus.State_Dbg, obs} !== {SF2, EF2W}) begin
      n_err++;
      $display("FAIL rst_mid_pre: got state=%0d outs=%h want state=%0d outs=%h",
               bus.State_Dbg, obs, SF2, EF2W);
    end
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({bus.State_Dbg, bus.MIO_EN, obs} !== {SHalt, 1'b0, 25'd0}) begin
      n_err++;
      $display("FAIL rst_mid_halt: got state=%0d mio_en=%b outs=%h want state=%0d mio_en=0 outs=0",
               bus.State_Dbg, bus.MIO_EN, obs, SHalt);
    end
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      n_cmp++;
      if (bus.State_Dbg !== SHalt) begin
        n_err++;
        $display("FAIL halt_without_run: got state=%0d want %0d", bus.State_Dbg, SHalt);
      end
    end
    bus.Run = 1'b1;
    @(negedge Clk);
    bus.Run = 1'b0;
    n_cmp++;
    if ({bus.State_Dbg, obs} !== {SF1, EF1}) begin
      n_err++;
      $display("FAIL rerun_fetch1: got state=%0d outs=%h want state=%0d outs=%h",
               bus.State_Dbg, obs, SF1, EF1);
    end
    // Counter must restart cleanly after the reset that cut FETCH2 short.
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      n_cmp++;
      if ({bus.State_Dbg, obs} !== pre(c)) begin
        n_err++;
        $display("FAIL rerun_fetch cyc %0d: got state=%0d outs=%h want %h",
                 c, bus.State_Dbg, obs, pre(c));
      end
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    Reset        = 1'b0;
    bus.Run      = 1'b0;
    bus.Continue = 1'b0;
    bus.IR_15_12 = 4'b0000;
    bus.IR_11    = 1'b0;
    bus.BEN      = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_jsr();
    test_mem();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
